// File: rtl/morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_key_decoder
// Purpose  : Debounces a raw key and classifies presses as dot or dash.
//            Decodes 5-symbol Morse digits into a 0-9 value with load/invalid strobes.
// Revision : 1.0 - initial release
// ============================================================================
module morse_key_decoder #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DASH_CYC     = 15000000,
    parameter int IDLE_CYC     = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       key,
    output logic [3:0] digit,
    output logic       load,
    output logic       invalid,
    output logic [4:0] symbols,
    output logic [2:0] symbol_count,
    output logic       busy
);

    localparam int c_db_w    = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_press_w = $clog2(DASH_CYC + 1);
    localparam int c_gap_w   = $clog2(IDLE_CYC + 1);

    localparam logic [c_db_w-1:0]    c_db_last   = c_db_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_db_w-1:0]    c_db_one    = c_db_w'(1);
    localparam logic [c_press_w-1:0] c_press_max = c_press_w'(DASH_CYC);
    localparam logic [c_press_w-1:0] c_press_one = c_press_w'(1);
    localparam logic [c_gap_w-1:0]   c_gap_max   = c_gap_w'(IDLE_CYC);
    localparam logic [c_gap_w-1:0]   c_gap_one   = c_gap_w'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input path: synchronizer, debounce, edge detect
    // ------------------------------------------------------------------
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              key_db_q, key_db_d;
    logic              key_db_dly_q, key_db_dly_d;
    logic [c_db_w-1:0] db_cnt_q, db_cnt_d;
    logic              db_rise;
    logic              db_fall;

    always_comb begin
        sync1_d      = key;
        sync2_d      = sync1_q;
        key_db_dly_d = key_db_q;
        key_db_d     = key_db_q;
        db_cnt_d     = '0;
        if (sync2_q != key_db_q) begin
            if (db_cnt_q == c_db_last) begin
                key_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + c_db_one;
            end
        end
    end

    assign db_rise = key_db_q & ~key_db_dly_q;
    assign db_fall = ~key_db_q & key_db_dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            key_db_q     <= 1'b0;
            key_db_dly_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_dly_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Symbol collection FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [4:0]           symbols_q, symbols_d;
    logic [2:0]           count_q, count_d;
    logic [c_press_w-1:0] press_q, press_d;
    logic [c_gap_w-1:0]   gap_q, gap_d;
    logic [3:0]           digit_q, digit_d;
    logic                 load_q, load_d;
    logic                 invalid_q, invalid_d;

    logic [c_press_w-1:0] press_sat;
    logic [c_gap_w-1:0]   gap_sat;
    logic                 is_dash;
    logic [2:0]           sym_idx;
    logic                 lut_ok;
    logic [3:0]           lut_digit;

    assign press_sat = (press_q == c_press_max) ? press_q : press_q + c_press_one;
    assign gap_sat   = (gap_q == c_gap_max) ? gap_q : gap_q + c_gap_one;
    assign is_dash   = (press_q >= c_press_max);
    assign sym_idx   = 3'd4 - count_q;

    always_comb begin
        lut_ok    = 1'b1;
        lut_digit = 4'd0;
        case (symbols_q)
            5'b11111: lut_digit = 4'd0;
            5'b01111: lut_digit = 4'd1;
            5'b00111: lut_digit = 4'd2;
            5'b00011: lut_digit = 4'd3;
            5'b00001: lut_digit = 4'd4;
            5'b00000: lut_digit = 4'd5;
            5'b10000: lut_digit = 4'd6;
            5'b11000: lut_digit = 4'd7;
            5'b11100: lut_digit = 4'd8;
            5'b11110: lut_digit = 4'd9;
            default:  lut_ok    = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        symbols_d = symbols_q;
        count_d   = count_q;
        press_d   = press_q;
        gap_d     = gap_q;
        digit_d   = digit_q;
        load_d    = 1'b0;
        invalid_d = 1'b0;

        // Abort has priority over everything, including a pending DONE lookup.
        if (clear || !enable) begin
            state_d   = IDLE;
            symbols_d = '0;
            count_d   = '0;
            press_d   = '0;
            gap_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (db_rise) begin
                        state_d = PRESS;
                        press_d = '0;
                    end
                end
                PRESS: begin
                    press_d = press_sat;
                    if (db_fall) begin
                        symbols_d[sym_idx] = is_dash;
                        count_d            = count_q + 3'd1;
                        if (count_q == 3'd4) begin
                            state_d = DONE;
                        end else begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end
                end
                GAP: begin
                    gap_d = gap_sat;
                    // Timeout is checked first so it wins over a simultaneous press.
                    if (gap_sat == c_gap_max) begin
                        invalid_d = 1'b1;
                        symbols_d = '0;
                        count_d   = '0;
                        gap_d     = '0;
                        state_d   = IDLE;
                    end else if (db_rise) begin
                        state_d = PRESS;
                        press_d = '0;
                    end
                end
                DONE: begin
                    state_d   = IDLE;
                    symbols_d = '0;
                    count_d   = '0;
                    if (lut_ok) begin
                        digit_d = lut_digit;
                        load_d  = 1'b1;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            symbols_q <= '0;
            count_q   <= '0;
            press_q   <= '0;
            gap_q     <= '0;
            digit_q   <= '0;
            load_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            symbols_q <= symbols_d;
            count_q   <= count_d;
            press_q   <= press_d;
            gap_q     <= gap_d;
            digit_q   <= digit_d;
            load_q    <= load_d;
            invalid_q <= invalid_d;
        end
    end

    assign digit        = digit_q;
    assign load         = load_q;
    assign invalid      = invalid_q;
    assign symbols      = symbols_q;
    assign symbol_count = count_q;
    assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_key_decoder
// Purpose  : Self-checking bench: table of Morse codes plus directed corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_key_decoder;

    localparam int DEB         = 4;
    localparam int DASH        = 20;
    localparam int IDLE        = 50;
    localparam int DOT_LEN     = 8;
    localparam int DASH_LEN    = 30;
    localparam int GAP_LEN     = 10;
    // key release -> load: 2 sync + DEB debounce + fall detect + DONE
    localparam int LOAD_LAT    = 2 + DEB + 2;
    // key release -> timeout: 2 sync + DEB debounce + fall detect + IDLE gap cycles
    localparam int TIMEOUT_LAT = 2 + DEB + 1 + IDLE;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       enable = 1'b0;
    logic       clear  = 1'b0;
    logic       key    = 1'b0;
    logic [3:0] digit;
    logic       load;
    logic       invalid;
    logic [4:0] symbols;
    logic [2:0] symbol_count;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int load_cnt  = 0;
    int inv_cnt   = 0;
    int both_cnt  = 0;
    int last_load = -1;
    int last_inv  = -1;

    morse_key_decoder #(
        .DEBOUNCE_CYC (DEB),
        .DASH_CYC     (DASH),
        .IDLE_CYC     (IDLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .key          (key),
        .digit        (digit),
        .load         (load),
        .invalid      (invalid),
        .symbols      (symbols),
        .symbol_count (symbol_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        int         nsym;
        int         tail;
        int         exp_digit;
        int         exp_load;
        int         exp_inv;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (load) begin
            load_cnt++;
            last_load = cyc;
        end
        if (invalid) begin
            inv_cnt++;
            last_inv = cyc;
        end
        if (load && invalid) both_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press_sym(input logic dash, output int rel);
        key = 1'b1;
        ticks(dash ? DASH_LEN : DOT_LEN);
        key = 1'b0;
        rel = cyc;
        ticks(GAP_LEN);
    endtask

    // Enters the first nsym symbols of code, checking the partial shift register.
    task automatic enter_code(input logic [4:0] code, input int nsym, input string tag,
                              output int rel);
        logic [4:0] mask;
        for (int i = 0; i < nsym; i++) begin
            press_sym(code[4-i], rel);
            if (i < 4) begin
                mask = 5'b11111 << (4 - i);
                chk($sformatf("%s_sym%0d", tag, i), int'(symbols), int'(code & mask));
                chk($sformatf("%s_cnt%0d", tag, i), int'(symbol_count), i + 1);
                chk($sformatf("%s_busy%0d", tag, i), int'(busy), 1);
            end
        end
    endtask

    function automatic int all_outs();
        return int'({digit, load, invalid, symbols, symbol_count, busy});
    endfunction

    initial begin
        int rel;
        int ld0;
        int iv0;
        int busy_hi;

        vecs[0]  = '{5'b00111, 5, 0,  2, 1, 0, LOAD_LAT};
        vecs[1]  = '{5'b10101, 5, 0,  2, 0, 1, LOAD_LAT};
        vecs[2]  = '{5'b00000, 3, 50, 2, 0, 1, TIMEOUT_LAT};
        vecs[3]  = '{5'b11111, 5, 0,  0, 1, 0, LOAD_LAT};
        vecs[4]  = '{5'b10000, 5, 0,  6, 1, 0, LOAD_LAT};
        vecs[5]  = '{5'b00000, 5, 0,  5, 1, 0, LOAD_LAT};
        vecs[6]  = '{5'b11110, 5, 0,  9, 1, 0, LOAD_LAT};
        vecs[7]  = '{5'b01111, 5, 0,  1, 1, 0, LOAD_LAT};
        vecs[8]  = '{5'b11000, 5, 0,  7, 1, 0, LOAD_LAT};
        vecs[9]  = '{5'b00001, 5, 0,  4, 1, 0, LOAD_LAT};
        vecs[10] = '{5'b01010, 5, 0,  4, 0, 1, LOAD_LAT};
        vecs[11] = '{5'b00011, 5, 0,  3, 1, 0, LOAD_LAT};

        // Reset held while the key toggles
        for (int i = 0; i < 3; i++) begin
            key = ~key;
            tick();
            chk($sformatf("rst_hold%0d", i), all_outs(), 0);
        end
        key    = 1'b0;
        rst    = 1'b1;
        enable = 1'b1;
        ticks(10);
        chk("rst_release", all_outs(), 0);
        chk("rst_no_pulse", load_cnt + inv_cnt, 0);

        // Table of codes
        for (int v = 0; v < 12; v++) begin
            ld0 = load_cnt;
            iv0 = inv_cnt;
            enter_code(vecs[v].code, vecs[v].nsym, $sformatf("v%0d", v), rel);
            ticks(vecs[v].tail);
            chk($sformatf("v%0d_load", v), load_cnt - ld0, vecs[v].exp_load);
            chk($sformatf("v%0d_inv", v), inv_cnt - iv0, vecs[v].exp_inv);
            if (vecs[v].exp_load != 0)
                chk($sformatf("v%0d_load_lat", v), last_load - rel, vecs[v].lat);
            else
                chk($sformatf("v%0d_inv_lat", v), last_inv - rel, vecs[v].lat);
            chk($sformatf("v%0d_digit", v), int'(digit), vecs[v].exp_digit);
            chk($sformatf("v%0d_cnt", v), int'(symbol_count), 0);
            chk($sformatf("v%0d_idle", v), int'(busy), 0);
        end

        // Bounce shorter than the debounce window never registers
        ld0 = load_cnt;
        iv0 = inv_cnt;
        busy_hi = 0;
        for (int i = 0; i < 10; i++) begin
            key = ~key;
            for (int k = 0; k < 2; k++) begin
                tick();
                if (busy) busy_hi++;
            end
        end
        key = 1'b0;
        ticks(10);
        chk("bounce_busy", busy_hi, 0);
        chk("bounce_cnt", int'(symbol_count), 0);
        chk("bounce_pulses", (load_cnt - ld0) + (inv_cnt - iv0), 0);

        // Asynchronous reset in the middle of a press
        enter_code(5'b11000, 2, "r", rel);
        key = 1'b1;
        ticks(10);
        chk("mid_press_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 0);
        key = 1'b0;
        ticks(3);
        rst = 1'b1;
        ld0 = load_cnt;
        iv0 = inv_cnt;
        ticks(10);
        chk("post_rst_outs", all_outs(), 0);
        enter_code(5'b11111, 5, "z", rel);
        chk("z_load", load_cnt - ld0, 1);
        chk("z_inv", inv_cnt - iv0, 0);
        chk("z_load_lat", last_load - rel, LOAD_LAT);
        chk("z_digit", int'(digit), 0);

        // enable low discards a partial sequence silently
        enter_code(5'b00000, 2, "e", rel);
        ld0 = load_cnt;
        iv0 = inv_cnt;
        enable = 1'b0;
        tick();
        chk("en_cnt", int'(symbol_count), 0);
        chk("en_sym_busy", int'(busy), 0);
        enable = 1'b1;
        ticks(60);
        chk("en_pulses", (load_cnt - ld0) + (inv_cnt - iv0), 0);

        // clear during the DONE cycle suppresses the strobe
        enter_code(5'b10000, 4, "c", rel);
        ld0 = load_cnt;
        iv0 = inv_cnt;
        press_sym(1'b0, rel);
        chk("c_early_pulses", (load_cnt - ld0) + (inv_cnt - iv0), 1);
        // Rerun the last symbol with clear aligned to DONE
        enter_code(5'b10000, 4, "d", rel);
        ld0 = load_cnt;
        iv0 = inv_cnt;
        key = 1'b1;
        ticks(DOT_LEN);
        key = 1'b0;
        rel = cyc;
        ticks(LOAD_LAT - 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ticks(20);
        chk("d_pulses", (load_cnt - ld0) + (inv_cnt - iv0), 0);
        chk("d_digit", int'(digit), 6);
        chk("d_cnt", int'(symbol_count), 0);
        chk("d_idle", int'(busy), 0);

        chk("load_inv_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
